// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scanner: double-buffered data, leading-zero blanking,
// frame pulse. Define SEVSEG_DIM_EN to add the bright[3:0] PWM dimming input.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    en,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]              bright,
`endif
    output logic [6:0]              sev_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]         CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic [CW-1:0]           count, count_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    tick, wrap;
    logic [4*NUM_DIGITS-1:0] shd_data, act_data, act_data_nxt;
    logic [NUM_DIGITS-1:0]   shd_dp, act_dp, act_dp_nxt;
    logic [NUM_DIGITS-1:0]   lz_mask, onehot, an_nxt;
    logic                    all_zero, cur_dp, blanked, phase_on, show, dp_nxt;
    logic [3:0]              cur_nib;
    logic [6:0]              seg, sev_nxt;

    // Active-low segment pattern {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        tick         = en && (count == CNT_MAX);
        wrap         = tick && (idx == IDX_MAX);
        count_nxt    = count;
        idx_nxt      = idx;
        if (en)   count_nxt = tick ? '0 : count + CW'(1);
        if (tick) idx_nxt   = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        act_data_nxt = act_data;
        act_dp_nxt   = act_dp;
        // A load landing on the wrap bypasses the shadow so it is not a frame late
        if (wrap) begin
            act_data_nxt = load ? data_in : shd_data;
            act_dp_nxt   = load ? dp_in   : shd_dp;
        end
    end

    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (act_data_nxt[4*k +: 4] == 4'h0);
            lz_mask[k] = all_zero;
        end
    end

    // Outputs are computed from next-cycle state so an/sev_out switch together with the index
    always_comb begin
        cur_nib = 4'(act_data_nxt >> {idx_nxt, 2'b00});
        cur_dp  = 1'(act_dp_nxt >> idx_nxt);
        blanked = blank_lz && 1'(lz_mask >> idx_nxt);
        onehot  = AN_ONE << idx_nxt;
`ifdef SEVSEG_DIM_EN
        phase_on = (4'(count_nxt / CW'(CLK_DIV / 16)) <= bright);
`else
        phase_on = 1'b1;
`endif
        show    = en && !blanked && phase_on;
        seg     = seg_decode(cur_nib);
        an_nxt  = show ? (AN_ACTIVE_LOW ? ~onehot : onehot) : AN_OFF;
        sev_nxt = show ? (SEG_ACTIVE_LOW ? seg : ~seg) : SEG_OFF;
        dp_nxt  = show ? (SEG_ACTIVE_LOW ? ~cur_dp : cur_dp) : SEG_ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            count      <= '0;
            idx        <= '0;
            shd_data   <= '0;
            shd_dp     <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            an         <= AN_OFF;
            sev_out    <= SEG_OFF;
            dp_out     <= SEG_ACTIVE_LOW;
            frame_done <= 1'b0;
        end else begin
            count    <= count_nxt;
            idx      <= idx_nxt;
            act_data <= act_data_nxt;
            act_dp   <= act_dp_nxt;
            if (load) begin
                shd_data <= data_in;
                shd_dp   <= dp_in;
            end
            an         <= an_nxt;
            sev_out    <= sev_nxt;
            dp_out     <= dp_nxt;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (4 digits, 16 clocks per slot) with a
// frame-position reference model and a second instance of opposite polarity.
module tb_sevenseg_scan_ctrl;
  localparam int N = 4;
  localparam int DIV = 16;
  localparam int FRAME = N * DIV;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic clk = 1'b0;
  logic Rst = 1'b1;
  logic load = 1'b0;
  logic blank_lz = 1'b0;
  logic en = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] bright = 4'd15;
  logic [6:0] sev_out, sev_out_p;
  logic dp_out, dp_out_p, frame_done, frame_done_p;
  logic [3:0] an, an_p;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .Rst(Rst), .data_in(data_in), .dp_in(dp_in), .load(load), .blank_lz(blank_lz), .en(en),
`ifdef SEVSEG_DIM_EN
    .bright(bright),
`endif
    .sev_out(sev_out), .dp_out(dp_out), .an(an), .frame_done(frame_done));

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_dut_p (
    .clk(clk), .Rst(Rst), .data_in(data_in), .dp_in(dp_in), .load(load), .blank_lz(blank_lz), .en(en),
`ifdef SEVSEG_DIM_EN
    .bright(bright),
`endif
    .sev_out(sev_out_p), .dp_out(dp_out_p), .an(an_p), .frame_done(frame_done_p));

  // Reference model: position = enabled cycles since reset; digit/slot follow by division
  int unsigned pos;
  logic [15:0] m_shadow, m_active;
  logic [3:0] m_sdp, m_adp;
  logic [3:0] exp_an;
  logic [6:0] exp_sev;
  logic exp_dp, exp_fd;

  always @(posedge clk) begin
    int d;
    logic w, on;
    if (Rst) begin
      pos = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
      exp_an = 4'hF; exp_sev = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      w = en && (pos % FRAME == FRAME - 1);
      if (w) begin
        m_active = load ? data_in : m_shadow;
        m_adp = load ? dp_in : m_sdp;
      end
      if (load) begin
        m_shadow = data_in;
        m_sdp = dp_in;
      end
      if (en) pos = pos + 1;
      exp_fd = w;
      d = (pos / DIV) % N;
      on = en && !(blank_lz && d != 0 && (m_active >> (4 * d)) == 16'h0);
`ifdef SEVSEG_DIM_EN
      if (((pos % DIV) / (DIV / 16)) > bright) on = 1'b0;
`endif
      exp_an = 4'hF; exp_sev = 7'h7F; exp_dp = 1'b1;
      if (on) begin
        exp_an = ~(4'b0001 << d);
        exp_sev = SEG_TAB[m_active[4*d +: 4]];
        exp_dp = ~m_adp[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (an !== 4'hF || sev_out !== 7'h7F || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_lo got an=%b sev=%b dp=%b fd=%b want 1111 1111111 1 0", an, sev_out, dp_out, frame_done);
    end
    checks++;
    if (an_p !== 4'h0 || sev_out_p !== 7'h00 || dp_out_p !== 1'b0 || frame_done_p !== 1'b0) begin
      errors++;
      $display("FAIL reset_hi got an=%b sev=%b dp=%b fd=%b want 0000 0000000 0 0", an_p, sev_out_p, dp_out_p, frame_done_p);
    end
    Rst = 1'b0;
    step();
    checks++;
    if (an !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_dark got an=%b fd=%b want 1111 0", an, frame_done);
    end
  endtask

  task automatic test_scan();
    logic [6:0] want_sev [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    bit found = 0;
    data_in = 16'h1234; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      checks++;
      if ({an, sev_out, dp_out, frame_done} !== {exp_an, exp_sev, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL scan_model t=%0t got %b %b %b %b want %b %b %b %b", $time, an, sev_out, dp_out, frame_done, exp_an, exp_sev, exp_dp, exp_fd);
      end
      if (frame_done === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_first_wrap got no frame_done want one within %0d cycles", 2 * FRAME);
    end
    for (int k = 0; k <= FRAME; k++) begin
      if (k > 0) step();
      checks++;
      if (k < FRAME && (an !== ~(4'b0001 << (k / DIV)) || sev_out !== want_sev[k / DIV] || frame_done !== (k == 0))) begin
        errors++;
        $display("FAIL scan_slot k=%0d got an=%b sev=%b fd=%b want an=%b sev=%b fd=%b", k, an, sev_out, frame_done, ~(4'b0001 << (k / DIV)), want_sev[k / DIV], k == 0);
      end
      if (k == FRAME && (frame_done !== 1'b1 || an !== 4'b1110)) begin
        errors++;
        $display("FAIL scan_period got fd=%b an=%b want 1 1110", frame_done, an);
      end
    end
  endtask

  task automatic test_tear();
    bit found = 0;
    repeat (20) step();
    data_in = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      checks++;
      if ({an, sev_out, dp_out, frame_done} !== {exp_an, exp_sev, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL tear_model t=%0t got %b %b %b %b want %b %b %b %b", $time, an, sev_out, dp_out, frame_done, exp_an, exp_sev, exp_dp, exp_fd);
      end
      if (frame_done === 1'b1) begin
        found = 1;
        checks++;
        if (an !== 4'b1110 || sev_out !== 7'b1000010) begin
          errors++;
          $display("FAIL tear_new got an=%b sev=%b want 1110 1000010", an, sev_out);
        end
      end else if (an === 4'b1011 || an === 4'b0111) begin
        checks++;
        if (sev_out !== ((an === 4'b1011) ? 7'b0010010 : 7'b1001111)) begin
          errors++;
          $display("FAIL tear_old got an=%b sev=%b want old 1234 digit", an, sev_out);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tear_wrap got no frame_done want one within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic test_collision();
    // Now observing slot position 0; step to the wrap cycle (position FRAME-1)
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      checks++;
      if ({an, sev_out, dp_out, frame_done} !== {exp_an, exp_sev, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL coll_model t=%0t got %b %b %b %b want %b %b %b %b", $time, an, sev_out, dp_out, frame_done, exp_an, exp_sev, exp_dp, exp_fd);
      end
    end
    data_in = 16'h00F0; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || an !== 4'b1110 || sev_out !== 7'b0000001) begin
      errors++;
      $display("FAIL coll_digit0 got fd=%b an=%b sev=%b want 1 1110 0000001", frame_done, an, sev_out);
    end
    repeat (DIV) step();
    checks++;
    if (an !== 4'b1101 || sev_out !== 7'b0111000) begin
      errors++;
      $display("FAIL coll_digit1 got an=%b sev=%b want 1101 0111000", an, sev_out);
    end
  endtask

  task automatic test_blank();
    bit found = 0;
    blank_lz = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (an[3:2] !== 2'b11 || (an === 4'b1101 && sev_out !== 7'b0111000) || (an === 4'b1110 && sev_out !== 7'b0000001)) begin
        errors++;
        $display("FAIL blank_00f0 got an=%b sev=%b want digits 3,2 dark, 1=F, 0=0", an, sev_out);
      end
    end
    data_in = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL blank_wrap got no frame_done want one within %0d cycles", 2 * FRAME);
    end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step();
      checks++;
      if (an !== ((k < DIV) ? 4'b1110 : 4'b1111) || sev_out !== ((k < DIV) ? 7'b0000001 : 7'b1111111)) begin
        errors++;
        $display("FAIL blank_zero k=%0d got an=%b sev=%b", k, an, sev_out);
      end
      checks++;
      if ({an, sev_out, dp_out, frame_done} !== {exp_an, exp_sev, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL blank_model t=%0t got %b %b %b %b want %b %b %b %b", $time, an, sev_out, dp_out, frame_done, exp_an, exp_sev, exp_dp, exp_fd);
      end
    end
  endtask

  task automatic test_enable_reset();
    bit found = 0;
    bit done = 0;
    int lit = 0;
    blank_lz = 1'b0; data_in = 16'h5678; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      checks++;
      if ({an, sev_out, dp_out, frame_done} !== {exp_an, exp_sev, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL en_model t=%0t got %b %b %b %b want %b %b %b %b", $time, an, sev_out, dp_out, frame_done, exp_an, exp_sev, exp_dp, exp_fd);
      end
      if (an === 4'b1011 && pos > FRAME + 8) found = 1;
    end
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (an !== 4'hF || sev_out !== 7'h7F) begin
        errors++;
        $display("FAIL en_off got an=%b sev=%b want 1111 1111111", an, sev_out);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (an === 4'b1011) lit++;
      else done = 1;
    end
    checks++;
    if (lit != DIV - 1 || an !== 4'b0111) begin
      errors++;
      $display("FAIL en_resume got lit=%0d next_an=%b want %0d 0111", lit, an, DIV - 1);
    end
    data_in = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    checks++;
    if (an !== 4'hF || sev_out !== 7'h7F || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got an=%b sev=%b dp=%b fd=%b want 1111 1111111 1 0", an, sev_out, dp_out, frame_done);
    end
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1;
    end
    checks++;
    if (!found || an !== 4'b1110 || sev_out !== 7'b0000001) begin
      errors++;
      $display("FAIL rst_discard got found=%0d an=%b sev=%b want 1 1110 0000001", found, an, sev_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 1) == 0) data_in[15:8] = 8'h00;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      en = ($urandom_range(0, 9) != 0);
      Rst = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if ({an, sev_out, dp_out, frame_done} !== {exp_an, exp_sev, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL rand_model t=%0t got %b %b %b %b want %b %b %b %b", $time, an, sev_out, dp_out, frame_done, exp_an, exp_sev, exp_dp, exp_fd);
      end
      checks++;
      if ({an_p, sev_out_p, dp_out_p, frame_done_p} !== {~exp_an, ~exp_sev, ~exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL rand_polarity t=%0t got %b %b %b %b want %b %b %b %b", $time, an_p, sev_out_p, dp_out_p, frame_done_p, ~exp_an, ~exp_sev, ~exp_dp, exp_fd);
      end
    end
    Rst = 1'b0; load = 1'b0; en = 1'b1; blank_lz = 1'b0;
  endtask

`ifdef SEVSEG_DIM_EN
  task automatic test_dim();
    logic [3:0] levels [2] = '{4'd3, 4'd15};
    for (int l = 0; l < 2; l++) begin
      bit found = 0;
      int lit = 0;
      bright = levels[l];
      data_in = 16'h8888; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
        step();
        if (frame_done === 1'b1 && pos > FRAME) found = 1;
      end
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) step();
        if (an !== 4'hF) lit++;
        checks++;
        if ((an !== 4'hF) !== ((k % DIV) <= int'(levels[l])) || an_p !== ~an) begin
          errors++;
          $display("FAIL dim_phase b=%0d k=%0d got an=%b an_p=%b", levels[l], k, an, an_p);
        end
      end
      checks++;
      if (!found || lit != N * (int'(levels[l]) + 1)) begin
        errors++;
        $display("FAIL dim_duty b=%0d got lit=%0d want %0d", levels[l], lit, N * (int'(levels[l]) + 1));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_collision();
    test_blank();
    test_enable_reset();
    test_random();
`ifdef SEVSEG_DIM_EN
    test_dim();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
